// File: rtl/csplit2_steer_cache.sv
// csplit2_steer_cache: clocked 1-to-2 drive/free token steering split with per-channel credits.
// Optional macro CSPLIT_STEER_STAT_EN adds per-channel 16-bit dispatch counters.
`default_nettype none

module csplit2_steer_cache #(
   parameter int DATA_W  = 1,
   parameter int CREDITS = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_drive,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_sel,
   output logic              o_free,
   output logic              o_drive0,
   output logic [DATA_W-1:0] o_data0,
   input  logic              i_free0,
   output logic              o_drive1,
   output logic [DATA_W-1:0] o_data1,
   input  logic              i_free1,
   output logic              o_err
`ifdef CSPLIT_STEER_STAT_EN
   ,
   output logic [15:0]       o_cnt0,
   output logic [15:0]       o_cnt1
`endif
);

   typedef enum logic [0:0] {
      ST_EMPTY = 1'b0,
      ST_HELD  = 1'b1
   } state_t;

   localparam logic [2:0] C_CRED = 3'(CREDITS);

   state_t            r_state;
   logic [DATA_W-1:0] r_hold_data;
   logic              r_hold_sel;
   logic [2:0]        r_cred0;
   logic [2:0]        r_cred1;
   logic              r_free;
   logic              r_drive0;
   logic              r_drive1;
   logic [DATA_W-1:0] r_data0;
   logic [DATA_W-1:0] r_data1;
   logic              r_err;

   logic [2:0]        w_cred_sel;
   logic              w_disp;
   logic              w_disp0;
   logic              w_disp1;
   logic              w_sat0;
   logic              w_sat1;
   logic              w_ovf;
   logic [2:0]        w_cred0_nxt;
   logic [2:0]        w_cred1_nxt;

   // Dispatch decision uses the registered credit, so a credit returned at
   // edge j releases a stalled token at edge j+1.
   assign w_cred_sel = r_hold_sel ? r_cred1 : r_cred0;
   assign w_disp     = (r_state == ST_HELD) && (w_cred_sel != 3'd0);
   assign w_disp0    = w_disp && !r_hold_sel;
   assign w_disp1    = w_disp &&  r_hold_sel;

   assign w_sat0 = i_free0 && !w_disp0 && (r_cred0 == C_CRED);
   assign w_sat1 = i_free1 && !w_disp1 && (r_cred1 == C_CRED);
   assign w_ovf  = i_drive && (r_state == ST_HELD);

   always_comb begin
      w_cred0_nxt = r_cred0;
      if (i_free0 && !w_disp0 && !w_sat0) begin
         w_cred0_nxt = r_cred0 + 3'd1;
      end else if (w_disp0 && !i_free0) begin
         w_cred0_nxt = r_cred0 - 3'd1;
      end
   end

   always_comb begin
      w_cred1_nxt = r_cred1;
      if (i_free1 && !w_disp1 && !w_sat1) begin
         w_cred1_nxt = r_cred1 + 3'd1;
      end else if (w_disp1 && !i_free1) begin
         w_cred1_nxt = r_cred1 - 3'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= ST_EMPTY;
         r_hold_data <= '0;
         r_hold_sel  <= 1'b0;
         r_cred0     <= C_CRED;
         r_cred1     <= C_CRED;
         r_free      <= 1'b0;
         r_drive0    <= 1'b0;
         r_drive1    <= 1'b0;
         r_data0     <= '0;
         r_data1     <= '0;
         r_err       <= 1'b0;
      end else begin
         r_free   <= w_disp;
         r_drive0 <= w_disp0;
         r_drive1 <= w_disp1;
         if (w_disp0) begin
            r_data0 <= r_hold_data;
         end
         if (w_disp1) begin
            r_data1 <= r_hold_data;
         end
         r_cred0 <= w_cred0_nxt;
         r_cred1 <= w_cred1_nxt;
         if (w_ovf || w_sat0 || w_sat1) begin
            r_err <= 1'b1;
         end
         case (r_state)
            ST_EMPTY: begin
               if (i_drive) begin
                  r_hold_data <= i_data;
                  r_hold_sel  <= i_sel;
                  r_state     <= ST_HELD;
               end
            end
            ST_HELD: begin
               // A drive arriving here is an overflow and is simply dropped.
               if (w_disp) begin
                  r_state <= ST_EMPTY;
               end
            end
            default: r_state <= ST_EMPTY;
         endcase
      end
   end

   assign o_free   = r_free;
   assign o_drive0 = r_drive0;
   assign o_drive1 = r_drive1;
   assign o_data0  = r_data0;
   assign o_data1  = r_data1;
   assign o_err    = r_err;

`ifdef CSPLIT_STEER_STAT_EN
   logic [15:0] r_cnt0;
   logic [15:0] r_cnt1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt0 <= 16'd0;
         r_cnt1 <= 16'd0;
      end else begin
         if (w_disp0) begin
            r_cnt0 <= r_cnt0 + 16'd1;
         end
         if (w_disp1) begin
            r_cnt1 <= r_cnt1 + 16'd1;
         end
      end
   end

   assign o_cnt0 = r_cnt0;
   assign o_cnt1 = r_cnt1;
`endif

endmodule

`default_nettype wire
